// File: rtl/mac_stop_ctrl.sv
// Sequences a full C = A*B pass over mac_stop_mem with one multiply-accumulate datapath.
// Latency: start -> first read 1 cycle; K+2 cycles per C element; done = M*N*(K+2)+1 cycles after start.
// Backpressure: none; the store has fixed 1-cycle read latency, and start is ignored unless IDLE.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start / busy / done  pass request, pass-in-progress flag, one-cycle completion pulse
//   row/col_addr_a/b/c   store addresses (all registered)
//   matrix_a_re/b_re     read enables; data_out_a/b return one cycle later
//   matrix_c_we          C write enable, with data_in_c as the write data
//
// Build option: define MAC_STOP_CTRL_SIGNED_EN for two's-complement A/B and a signed C;
// without it all operands are unsigned. Sequencing is identical in both builds.

module mac_stop_ctrl #(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K),
    // Address widths are kept at least one bit so single-row/column shapes still elaborate.
    localparam int MW = (M > 1) ? $clog2(M) : 1,
    localparam int KW = (K > 1) ? $clog2(K) : 1,
    localparam int NW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [MW-1:0]                       row_addr_a,
    output logic [KW-1:0]                       col_addr_a,
    output logic [KW-1:0]                       row_addr_b,
    output logic [NW-1:0]                       col_addr_b,
    output logic [MW-1:0]                       row_addr_c,
    output logic [NW-1:0]                       col_addr_c,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic                                matrix_c_we,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c
);

    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;

    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_DRAIN,
        S_WR,
        S_FIN
    } state_t;

    state_t          state;
    logic            rd_vld;     // tags the cycle in which a read issued last cycle returns data
    logic [RW-1:0]   acc;

    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   prod;
    logic [RW-1:0]   acc_base;
    logic [RW-1:0]   acc_next;

    // Operands are widened to the accumulator width before multiplying. The exact product
    // fits in 2*DW bits, so the low RW bits of the RW x RW product are the correctly
    // zero- or sign-extended product in either build.
    always_comb begin
`ifdef MAC_STOP_CTRL_SIGNED_EN
        a_ext = {{(RW - DW){data_out_a[DW-1]}}, data_out_a};
        b_ext = {{(RW - DW){data_out_b[DW-1]}}, data_out_b};
`else
        a_ext = {{(RW - DW){1'b0}}, data_out_a};
        b_ext = {{(RW - DW){1'b0}}, data_out_b};
`endif
        prod = a_ext * b_ext;
    end

    // The accumulator restarts on the first read cycle of each element. No product is
    // valid in that cycle: the cycle before it was WR or IDLE, with no read issued.
    always_comb begin
        acc_base = acc;
        if (state == S_RD && col_addr_a == '0) begin
            acc_base = '0;
        end
        acc_next = acc_base;
        if (rd_vld) begin
            acc_next = acc_base + prod;
        end
    end

    // All outputs are registered. Each transition sets the outputs for the state being
    // entered, so they are valid for the whole of that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rd_vld      <= 1'b0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            row_addr_a  <= '0;
            col_addr_a  <= '0;
            row_addr_b  <= '0;
            col_addr_b  <= '0;
            row_addr_c  <= '0;
            col_addr_c  <= '0;
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            matrix_c_we <= 1'b0;
            data_in_c   <= '0;
        end else begin
            rd_vld      <= matrix_a_re;
            acc         <= acc_next;
            done        <= 1'b0;
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            matrix_c_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RD;
                        busy        <= 1'b1;
                        matrix_a_re <= 1'b1;
                        matrix_b_re <= 1'b1;
                        col_addr_a  <= '0;
                        row_addr_b  <= '0;
                    end
                end

                S_RD: begin
                    if (col_addr_a == K_LAST) begin
                        // Leave the k address at 0, ready for the next element.
                        state      <= S_DRAIN;
                        col_addr_a <= '0;
                        row_addr_b <= '0;
                    end else begin
                        matrix_a_re <= 1'b1;
                        matrix_b_re <= 1'b1;
                        col_addr_a  <= col_addr_a + KW'(1);
                        row_addr_b  <= row_addr_b + KW'(1);
                    end
                end

                S_DRAIN: begin
                    // The final product lands in this cycle; acc_next already includes it.
                    state       <= S_WR;
                    matrix_c_we <= 1'b1;
                    data_in_c   <= acc_next;
                end

                S_WR: begin
                    // The i/j step wraps both coordinates back to 0 after the last element.
                    if (col_addr_b == N_LAST) begin
                        col_addr_b <= '0;
                        col_addr_c <= '0;
                        if (row_addr_a == M_LAST) begin
                            row_addr_a <= '0;
                            row_addr_c <= '0;
                        end else begin
                            row_addr_a <= row_addr_a + MW'(1);
                            row_addr_c <= row_addr_c + MW'(1);
                        end
                    end else begin
                        col_addr_b <= col_addr_b + NW'(1);
                        col_addr_c <= col_addr_c + NW'(1);
                    end

                    if (col_addr_b == N_LAST && row_addr_a == M_LAST) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state       <= S_RD;
                        matrix_a_re <= 1'b1;
                        matrix_b_re <= 1'b1;
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Directed bench for mac_stop_ctrl with a behavioural model of the matrix store.
// Expected C values come from hand-computed constants or an independent dot-product function.
// The store model answers reads one cycle after the read enable, as the real store does.

module tb_mac_stop_ctrl;

    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 2 * DW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done;
    logic [1:0]    row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
    logic          matrix_a_re, matrix_b_re, matrix_c_we;
    logic [DW-1:0] data_out_a, data_out_b;
    logic [RW-1:0] data_in_c;

    mac_stop_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .row_addr_a (row_addr_a),
        .col_addr_a (col_addr_a),
        .row_addr_b (row_addr_b),
        .col_addr_b (col_addr_b),
        .row_addr_c (row_addr_c),
        .col_addr_c (col_addr_c),
        .matrix_a_re(matrix_a_re),
        .matrix_b_re(matrix_b_re),
        .matrix_c_we(matrix_c_we),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .data_in_c  (data_in_c)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] a_m [M][K];
    logic [DW-1:0] b_m [K][N];
    logic [RW-1:0] c_m [M][N];
    int            wr_row [M*N];
    int            wr_col [M*N];
    int            cw_n = 0;
    int            overlap = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    // Store model: registered read data, one cycle after the enable.
    always @(posedge clk) begin
        if (matrix_a_re) data_out_a <= a_m[row_addr_a][col_addr_a];
        if (matrix_b_re) data_out_b <= b_m[row_addr_b][col_addr_b];
    end

    // C write port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (matrix_c_we && (matrix_a_re || matrix_b_re)) overlap++;
        if (matrix_c_we && !reset) begin
            c_m[row_addr_c][col_addr_c] = data_in_c;
            if (cw_n < M*N) begin
                wr_row[cw_n] = int'(row_addr_c);
                wr_col[cw_n] = int'(col_addr_c);
            end
            cw_n++;
        end
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] dot(input int i, input int j);
        logic [RW-1:0] s = '0;
        for (int k = 0; k < K; k++) s += RW'({32'b0, a_m[i][k]} * {32'b0, b_m[k][j]});
        return s;
    endfunction

    // Runs one pass from a start pulse; optionally pulses start again at cycle pulse_at.
    // Checks busy at cycle 1, done latency, the single-cycle done pulse and address wrap.
    task automatic run_pass(input string name, input int pulse_at);
        int n = 0;
        int lat = 0;
        cw_n = 0;
        @(negedge clk);
        start = 1'b1;
        while (n < 300 && lat == 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check({name, "_busy_c1"}, RW'(busy), RW'(1));
            end
            if (n == pulse_at)     start = 1'b1;
            if (n == pulse_at + 1) start = 1'b0;
            if (done) lat = n;
        end
        check({name, "_done_latency"}, RW'(lat), RW'(97));
        check({name, "_busy_in_fin"}, RW'(busy), RW'(0));
        check({name, "_writes"}, RW'(cw_n), RW'(M*N));
        @(negedge clk);
        check({name, "_done_one_cycle"}, RW'(done), RW'(0));
        check({name, "_addr_wrap"},
              RW'({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}), RW'(0));
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = av;
                b_m[r][c] = bv;
            end
    endtask

    task automatic fill_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 32'd1 : 32'd0;
                b_m[r][c] = 32'(r * 4 + c + 1);
            end
    endtask

    task automatic check_all(input string name, input logic [RW-1:0] exp);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("%s_c%0d%0d", name, r, c), c_m[r][c], exp);
    endtask

    task automatic check_identity(input string name);
        for (int w = 0; w < M*N; w++) begin
            check($sformatf("%s_c%0d%0d", name, w / 4, w % 4), c_m[w / 4][w % 4], RW'(w + 1));
            check($sformatf("%s_order%0d", name, w), RW'(wr_row[w] * 4 + wr_col[w]), RW'(w));
        end
    endtask

    initial begin
        logic [DW-1:0] a_rows [4][4];
        logic [DW-1:0] b_rows [4][4];
        logic [RW-1:0] row0 [4];
        logic [RW-1:0] row3 [4];
        int            n;
        int            writes_at_reset;

        a_rows = '{'{4, 3, 2, 5}, '{3, 4, 5, 2}, '{5, 2, 4, 3}, '{2, 5, 3, 4}};
        b_rows = '{'{7, 6, 5, 8}, '{6, 7, 8, 5}, '{8, 5, 7, 6}, '{5, 8, 6, 7}};
        row0   = '{87, 95, 88, 94};
        row3   = '{88, 94, 95, 87};

        reset = 1'b1;
        start = 1'b0;
        fill_const(32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_done", RW'(done), RW'(0));
        check("rst_enables", RW'({matrix_a_re, matrix_b_re, matrix_c_we}), RW'(0));
        check("rst_addrs",
              RW'({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}), RW'(0));
        check("rst_data_in_c", data_in_c, RW'(0));
        reset = 1'b0;

        // Known product, with a stray start pulse at cycle 40 that must be ignored.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = a_rows[r][c];
                b_m[r][c] = b_rows[r][c];
            end
        run_pass("known", 40);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("known_row0_%0d", c), c_m[0][c], row0[c]);
            check($sformatf("known_row3_%0d", c), c_m[3][c], row3[c]);
        end
        for (int r = 1; r < 3; r++)
            for (int c = 0; c < 4; c++)
                check($sformatf("known_c%0d%0d", r, c), c_m[r][c], dot(r, c));

        // Identity: C = B, written in row-major order.
        fill_identity();
        run_pass("ident", 0);
        check_identity("ident");

        // Width extremes.
        fill_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_pass("ext", 0);
`ifdef MAC_STOP_CTRL_SIGNED_EN
        check_all("ext", RW'(4));
`else
        check_all("ext", 66'h3_FFFF_FFF8_0000_0004);
`endif

        fill_const(32'hFFFF_FFFF, 32'd2);
        run_pass("sgn", 0);
`ifdef MAC_STOP_CTRL_SIGNED_EN
        check_all("sgn", 66'h3_FFFF_FFFF_FFFF_FFF8);
`else
        check_all("sgn", 66'h7_FFFF_FFF8);
`endif

        // Reset mid-pass at cycle 50: eight writes done (cycles 6..48), none after.
        fill_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) c_m[r][c] = '0;
        cw_n = 0;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", RW'(busy), RW'(0));
        check("midrst_enables", RW'({matrix_a_re, matrix_b_re, matrix_c_we}), RW'(0));
        reset = 1'b0;
        writes_at_reset = cw_n;
        check("midrst_writes", RW'(writes_at_reset), RW'(8));
        repeat (20) @(negedge clk);
        check("midrst_no_more_writes", RW'(cw_n), RW'(8));
        check("midrst_idle", RW'({busy, done}), RW'(0));

        // Restart after the aborted pass.
        run_pass("restart", 0);
        check_identity("restart");

        check("we_re_overlap", RW'(overlap), RW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
